lnrv_icb2apb: RTL and testbench
===============================

# lnrv_icb2apb

ICB-to-APB4 bridge that sits directly downstream of one `lnrv_icb_demux` slave port and drives a single APB4 peripheral segment (timers, UART, GPIO). The bridge accepts one ICB command, runs one APB SETUP/ACCESS transfer and returns one ICB response. It supports one outstanding transaction and has an optional PREADY timeout so a hung peripheral cannot stall the ICB fabric.

## Interface
- P_ADDR_WIDTH, 32, ICB/APB address width
- P_DATA_WIDTH, 32, data width; only 32 is supported
- P_TIMEOUT, 256, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  synchronous, active-high reset
- s_icb_cmd_vld / s_icb_cmd_rdy  in/out  1  command handshake
- s_icb_cmd_write  in  1  1 = write
- s_icb_cmd_addr  in  P_ADDR_WIDTH  byte address
- s_icb_cmd_wdata  in  P_DATA_WIDTH  write data
- s_icb_cmd_wstrb  in  P_DATA_WIDTH/8  byte strobes
- s_icb_cmd_size  in  3  log2 of the byte count
- s_icb_rsp_vld / s_icb_rsp_rdy  out/in  1  response handshake
- s_icb_rsp_rdata  out  P_DATA_WIDTH  read data
- s_icb_rsp_err  out  1  error flag
- m_apb_psel, m_apb_penable, m_apb_pwrite  out  1  APB control signals
- m_apb_paddr  out  P_ADDR_WIDTH; m_apb_pwdata  out  P_DATA_WIDTH; m_apb_pstrb  out  P_DATA_WIDTH/8; m_apb_pprot  out  3
- m_apb_pready, m_apb_pslverr  in  1; m_apb_prdata  in  P_DATA_WIDTH

## Operation
- FSM states: IDLE, SETUP, ACCESS, RSP.
- IDLE: s_icb_cmd_rdy=1. On a command handshake, latch write, addr, wdata, wstrb and size.
  - size>2: skip APB, go to RSP with err=1 and rdata=0.
  - Otherwise go to SETUP.
- SETUP: psel=1, penable=0. Always go to ACCESS after one cycle.
- ACCESS: psel=1, penable=1.
  - pready=1: capture rdata (prdata on reads, 0 on writes) and err=pslverr, then go to RSP.
  - Timeout: when the wait counter reaches P_TIMEOUT without pready, go to RSP with err=1 and rdata=0.
- RSP: s_icb_rsp_vld=1 until s_icb_rsp_rdy, then go to IDLE.
- s_icb_cmd_rdy=0 in every state except IDLE.
- paddr = latched addr; pwdata = latched wdata; pwrite = latched write.
- pstrb = latched wstrb on writes, 0 on reads (APB4 rule).
- pprot is fixed at 3'b000 (normal, secure, data).
- APB address, control and data outputs hold stable from SETUP through the end of ACCESS. Outside SETUP/ACCESS they hold their last value; psel and penable are 0.
- Wait counter: width clog2(P_TIMEOUT+1). It clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.

## Timing
- Reset values:
  - state=IDLE; psel, penable, pwrite = 0.
  - paddr, pwdata, pstrb, pprot = 0.
  - s_icb_rsp_vld, s_icb_rsp_err, s_icb_rsp_rdata = 0.
  - s_icb_cmd_rdy=1 from the first cycle after reset deasserts.
- All outputs are registered; s_icb_cmd_rdy is decoded from the state register.
- Latency with the command handshake at cycle N and zero-wait pready:
  - psel rises at N+1; penable at N+2.
  - s_icb_rsp_vld at N+3.
  - Earliest next command handshake is N+4 (response accepted at N+3).
- Each PREADY wait cycle adds 1. With the timeout enabled, the response arrives by N+3+P_TIMEOUT at the latest.
- Size error: s_icb_rsp_vld at N+1; no APB activity.
- s_icb_rsp_vld, s_icb_rsp_rdata and s_icb_rsp_err hold stable while s_icb_rsp_rdy=0.
- pready or pslverr in SETUP is ignored.
- Reset mid-transfer: at the next edge psel and penable drop without completion and any pending response is discarded.

## Structure
- Shared package `lnrv_apb_pkg`:
  - FSM state encoding (2 bits).
  - PPROT default constant.
  - APB4 size limit constant (max size = 2).
- A single flat module; no sub-module is natural. The response is held in FSM-owned registers, so no `lnrv_gnrl_buffer` instance is needed.

## Test plan
- Zero-wait read: addr=0x1000_0004, prdata=0xDEAD_BEEF, pready=1 in ACCESS.
  - psel at N+1, penable at N+2, rsp_vld at N+3.
  - rdata=0xDEAD_BEEF, err=0, pstrb=0.
- Write with 3 wait states: wdata=0x0000_00A5, wstrb=4'b0001.
  - pstrb=0001 and pwdata stable for all 4 ACCESS cycles; rsp at N+6, err=0.
- PSLVERR: read with pslverr=1 at pready.
  - err=1, rdata=0x0000_0000 regardless of prdata.
- Timeout: P_TIMEOUT=4, pready held 0.
  - ACCESS lasts exactly 5 cycles (4 waits + timeout); rsp err=1.
  - psel is 0 by the cycle rsp_vld rises.
- Backpressure and size error:
  - size=3 command: rsp_vld at N+1, err=1, no psel pulse.
  - Holding rsp_rdy=0 for 10 cycles keeps cmd_rdy=0 and rsp stable.
- Reset in ACCESS: assert reset during a wait state.
  - Next cycle psel=penable=0 and rsp_vld=0; cmd_rdy=1 after reset releases.

Source files
------------

// File: rtl/lnrv_apb_pkg.sv
// Shared definitions for the ICB-to-APB4 bridge: FSM encoding and APB4 constants.
package lnrv_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RSP    = 2'd3
    } state_t;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;
    // Largest transfer APB4 can carry on a 32-bit bus: 4 bytes (log2 = 2).
    localparam logic [2:0] APB_MAX_SIZE  = 3'd2;

endpackage

// File: rtl/lnrv_icb2apb.sv
// ICB-to-APB4 bridge: one outstanding ICB command becomes one APB SETUP/ACCESS
// transfer, with an optional PREADY timeout so a hung peripheral cannot stall ICB.
//
// state  | meaning
// IDLE   | accepting a command (cmd_rdy=1)
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready or timeout
// RSP    | holding the ICB response until rsp_rdy
module lnrv_icb2apb
    import lnrv_apb_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_TIMEOUT    = 256
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      s_icb_cmd_vld,
    output logic                      s_icb_cmd_rdy,
    input  logic                      s_icb_cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   s_icb_cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   s_icb_cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] s_icb_cmd_wstrb,
    input  logic [2:0]                s_icb_cmd_size,

    output logic                      s_icb_rsp_vld,
    input  logic                      s_icb_rsp_rdy,
    output logic [P_DATA_WIDTH-1:0]   s_icb_rsp_rdata,
    output logic                      s_icb_rsp_err,

    output logic                      m_apb_psel,
    output logic                      m_apb_penable,
    output logic                      m_apb_pwrite,
    output logic [P_ADDR_WIDTH-1:0]   m_apb_paddr,
    output logic [P_DATA_WIDTH-1:0]   m_apb_pwdata,
    output logic [P_DATA_WIDTH/8-1:0] m_apb_pstrb,
    output logic [2:0]                m_apb_pprot,
    input  logic                      m_apb_pready,
    input  logic                      m_apb_pslverr,
    input  logic [P_DATA_WIDTH-1:0]   m_apb_prdata
);

    // A disabled timeout still keeps a 1-bit counter so the width is never zero.
    localparam int CW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   wait_cnt;
    logic            cmd_hsk;
    logic            size_err;
    logic            timeout;

    assign s_icb_cmd_rdy = (state == ST_IDLE);
    assign cmd_hsk       = s_icb_cmd_vld && (state == ST_IDLE);
    assign size_err      = (s_icb_cmd_size > APB_MAX_SIZE);
    assign timeout       = (P_TIMEOUT != 0) && (wait_cnt == CW'(P_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cmd_hsk) begin
                    next_state = size_err ? ST_RSP : ST_SETUP;
                end
            end
            ST_SETUP:  next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (m_apb_pready || timeout) begin
                    next_state = ST_RSP;
                end
            end
            ST_RSP: begin
                if (s_icb_rsp_rdy) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_apb_psel      <= 1'b0;
            m_apb_penable   <= 1'b0;
            m_apb_pwrite    <= 1'b0;
            m_apb_paddr     <= '0;
            m_apb_pwdata    <= '0;
            m_apb_pstrb     <= '0;
            m_apb_pprot     <= '0;
            s_icb_rsp_vld   <= 1'b0;
            s_icb_rsp_rdata <= '0;
            s_icb_rsp_err   <= 1'b0;
            wait_cnt        <= '0;
        end else begin
            m_apb_psel    <= (next_state == ST_SETUP) || (next_state == ST_ACCESS);
            m_apb_penable <= (next_state == ST_ACCESS);
            s_icb_rsp_vld <= (next_state == ST_RSP);

            if (cmd_hsk && !size_err) begin
                m_apb_pwrite <= s_icb_cmd_write;
                m_apb_paddr  <= s_icb_cmd_addr;
                m_apb_pwdata <= s_icb_cmd_wdata;
                m_apb_pstrb  <= s_icb_cmd_write ? s_icb_cmd_wstrb : '0;
                m_apb_pprot  <= PPROT_DEFAULT;
            end

            if (cmd_hsk && size_err) begin
                s_icb_rsp_rdata <= '0;
                s_icb_rsp_err   <= 1'b1;
            end

            if (state == ST_SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ST_ACCESS) && !m_apb_pready) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            // A slave error returns zero data so stale read data never escapes.
            if ((state == ST_ACCESS) && m_apb_pready) begin
                s_icb_rsp_rdata <= (!m_apb_pwrite && !m_apb_pslverr) ? m_apb_prdata : '0;
                s_icb_rsp_err   <= m_apb_pslverr;
            end else if ((state == ST_ACCESS) && timeout) begin
                s_icb_rsp_rdata <= '0;
                s_icb_rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lnrv_icb2apb.sv
// Scoreboard bench for lnrv_icb2apb: stimulus pushes expected responses,
// a negedge monitor checks APB phases, latency and ICB responses.
module tb_lnrv_icb2apb;

    localparam int PT = 4;

    logic        clk;
    logic        reset;
    logic        s_icb_cmd_vld;
    logic        s_icb_cmd_rdy;
    logic        s_icb_cmd_write;
    logic [31:0] s_icb_cmd_addr;
    logic [31:0] s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wstrb;
    logic [2:0]  s_icb_cmd_size;
    logic        s_icb_rsp_vld;
    logic        s_icb_rsp_rdy;
    logic [31:0] s_icb_rsp_rdata;
    logic        s_icb_rsp_err;
    logic        m_apb_psel;
    logic        m_apb_penable;
    logic        m_apb_pwrite;
    logic [31:0] m_apb_paddr;
    logic [31:0] m_apb_pwdata;
    logic [3:0]  m_apb_pstrb;
    logic [2:0]  m_apb_pprot;
    logic        m_apb_pready;
    logic        m_apb_pslverr;
    logic [31:0] m_apb_prdata;

    lnrv_icb2apb #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32), .P_TIMEOUT(PT)) dut (
        .clk(clk), .reset(reset),
        .s_icb_cmd_vld(s_icb_cmd_vld), .s_icb_cmd_rdy(s_icb_cmd_rdy),
        .s_icb_cmd_write(s_icb_cmd_write), .s_icb_cmd_addr(s_icb_cmd_addr),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wstrb(s_icb_cmd_wstrb),
        .s_icb_cmd_size(s_icb_cmd_size),
        .s_icb_rsp_vld(s_icb_rsp_vld), .s_icb_rsp_rdy(s_icb_rsp_rdy),
        .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err),
        .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable),
        .m_apb_pwrite(m_apb_pwrite), .m_apb_paddr(m_apb_paddr),
        .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
        .m_apb_pprot(m_apb_pprot), .m_apb_pready(m_apb_pready),
        .m_apb_pslverr(m_apb_pslverr), .m_apb_prdata(m_apb_prdata)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          apb;
        int          lat;
        int          acc;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    int          cur_waits = 0;
    bit          cur_slverr = 0;
    logic [31:0] cur_prdata = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB slave: waits cur_waits ACCESS cycles, junk on handshake lines elsewhere.
    int acc_k = 0;
    always @(posedge clk) begin
        #1;
        if (m_apb_psel && m_apb_penable) begin
            acc_k++;
            m_apb_pready  = (acc_k > cur_waits);
            m_apb_pslverr = m_apb_pready ? cur_slverr : 1'($urandom);
            m_apb_prdata  = m_apb_pready ? cur_prdata : $urandom;
        end else begin
            acc_k = 0;
            m_apb_pready  = 1'($urandom);
            m_apb_pslverr = 1'($urandom);
            m_apb_prdata  = $urandom;
        end
    end

    // Monitor
    bit          in_flight = 0, have_cur = 0, prev_vld = 0, prev_hsk = 0;
    bit          saw_psel = 0, saw_pen = 0;
    int          hs_cyc = 0, first_psel = 0, first_pen = 0, acc_cnt = 0;
    logic [31:0] held_rdata;
    logic        held_err;

    always @(negedge clk) begin
        if (reset) begin
            in_flight = 0; have_cur = 0; prev_vld = 0; prev_hsk = 0;
        end else begin
            if (prev_hsk) check("rsp_vld_drop", {31'd0, s_icb_rsp_vld}, 32'd0);
            if (s_icb_rsp_vld) check("cmd_rdy_in_rsp", {31'd0, s_icb_cmd_rdy}, 32'd0);
            if (in_flight && m_apb_psel) begin
                if (!saw_psel) first_psel = cyc;
                saw_psel = 1;
                if (m_apb_penable) begin
                    if (!saw_pen) first_pen = cyc;
                    saw_pen = 1;
                    acc_cnt++;
                end
                if (have_cur) begin
                    check("paddr", m_apb_paddr, cur.addr);
                    check("pwrite", {31'd0, m_apb_pwrite}, {31'd0, cur.wr});
                    check("pwdata", m_apb_pwdata, cur.wdata);
                    check("pstrb", {28'd0, m_apb_pstrb}, {28'd0, cur.strb});
                    check("pprot", {29'd0, m_apb_pprot}, 32'd0);
                end
            end
            if (s_icb_rsp_vld && !prev_vld) begin
                check("rsp_expected", {31'd0, have_cur}, 32'd1);
                if (have_cur) begin
                    check("rsp_latency", hs_cyc + cur.lat, cyc);
                    check("rsp_rdata", s_icb_rsp_rdata, cur.rdata);
                    check("rsp_err", {31'd0, s_icb_rsp_err}, {31'd0, cur.err});
                    check("psel_at_rsp", {31'd0, m_apb_psel}, 32'd0);
                    check("apb_activity", {31'd0, saw_psel}, {31'd0, cur.apb});
                    if (cur.apb) begin
                        check("access_cycles", acc_cnt, cur.acc);
                        check("psel_latency", first_psel - hs_cyc, 1);
                        check("penable_latency", first_pen - hs_cyc, 2);
                    end
                end
                held_rdata = s_icb_rsp_rdata;
                held_err   = s_icb_rsp_err;
                in_flight  = 0;
                have_cur   = 0;
            end else if (s_icb_rsp_vld && prev_vld) begin
                check("rsp_rdata_stable", s_icb_rsp_rdata, held_rdata);
                check("rsp_err_stable", {31'd0, s_icb_rsp_err}, {31'd0, held_err});
            end
            if (s_icb_cmd_vld && s_icb_cmd_rdy) begin
                hs_cyc = cyc; in_flight = 1; saw_psel = 0; saw_pen = 0; acc_cnt = 0;
                have_cur = (exp_q.size() > 0);
                if (have_cur) cur = exp_q.pop_front();
            end
            prev_vld = s_icb_rsp_vld;
            prev_hsk = s_icb_rsp_vld && s_icb_rsp_rdy;
        end
    end

    // Drives one command, waits for its response, accepts it after bp held cycles.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [2:0] size, input int waits,
                          input bit slverr, input logic [31:0] prdata, input int bp,
                          input bit expect_rsp);
        exp_t e;
        int   n;
        bit   tmo;
        int   eff;
        tmo   = (waits > PT);
        eff   = (waits < PT) ? waits : PT;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.strb  = wr ? wstrb : 4'd0;
        e.apb   = (size <= 3'd2);
        e.lat   = e.apb ? 3 + eff : 1;
        e.acc   = eff + 1;
        e.err   = !e.apb || tmo || slverr;
        e.rdata = (!e.apb || tmo || wr || slverr) ? 32'd0 : prdata;
        if (expect_rsp) exp_q.push_back(e);
        cur_waits  = waits;
        cur_slverr = slverr;
        cur_prdata = prdata;
        @(posedge clk); #1;
        s_icb_cmd_vld   = 1'b1;
        s_icb_cmd_write = wr;
        s_icb_cmd_addr  = addr;
        s_icb_cmd_wdata = wdata;
        s_icb_cmd_wstrb = wstrb;
        s_icb_cmd_size  = size;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_icb_cmd_rdy && n < 20);
        if (!s_icb_cmd_rdy) check("cmd_handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_icb_cmd_vld   = 1'b0;
        s_icb_cmd_write = 1'($urandom);
        s_icb_cmd_addr  = $urandom;
        s_icb_cmd_wdata = $urandom;
        s_icb_cmd_wstrb = 4'($urandom);
        s_icb_cmd_size  = 3'($urandom);
        if (!expect_rsp) return;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_icb_rsp_vld && n < 50);
        if (!s_icb_rsp_vld) begin
            check("rsp_wait_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (bp) @(negedge clk);
        #1 s_icb_rsp_rdy = 1'b1;
        @(negedge clk);
        #1 s_icb_rsp_rdy = 1'b0;
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        s_icb_cmd_vld   = 1'b0;
        s_icb_cmd_write = 1'b0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wstrb = '0;
        s_icb_cmd_size  = '0;
        s_icb_rsp_rdy   = 1'b0;
        m_apb_pready    = 1'b0;
        m_apb_pslverr   = 1'b0;
        m_apb_prdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_psel", {31'd0, m_apb_psel}, 32'd0);
        check("rst_penable", {31'd0, m_apb_penable}, 32'd0);
        check("rst_pwrite", {31'd0, m_apb_pwrite}, 32'd0);
        check("rst_paddr", m_apb_paddr, 32'd0);
        check("rst_pwdata", m_apb_pwdata, 32'd0);
        check("rst_pstrb", {28'd0, m_apb_pstrb}, 32'd0);
        check("rst_pprot", {29'd0, m_apb_pprot}, 32'd0);
        check("rst_rsp_vld", {31'd0, s_icb_rsp_vld}, 32'd0);
        check("rst_rsp_err", {31'd0, s_icb_rsp_err}, 32'd0);
        check("rst_rsp_rdata", s_icb_rsp_rdata, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("cmd_rdy_after_reset", {31'd0, s_icb_cmd_rdy}, 32'd1);

        // Directed cases
        do_txn(1'b0, 32'h1000_0004, 32'h1234_5678, 4'hF, 3'd2, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b1);
        do_txn(1'b1, 32'h1000_0010, 32'h0000_00A5, 4'b0001, 3'd0, 3, 1'b0, 32'h5555_AAAA, 1, 1'b1);
        do_txn(1'b0, 32'h1000_0020, 32'h0, 4'hF, 3'd2, 1, 1'b1, 32'hCAFE_F00D, 0, 1'b1);
        do_txn(1'b0, 32'h1000_0030, 32'h0, 4'hF, 3'd2, 20, 1'b0, 32'h1111_2222, 0, 1'b1);
        do_txn(1'b1, 32'h1000_0040, 32'h7777_8888, 4'hF, 3'd3, 0, 1'b0, 32'h0, 10, 1'b1);
        do_txn(1'b0, 32'h1000_0044, 32'h0, 4'hF, 3'd1, 4, 1'b0, 32'h0BAD_CAFE, 2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [2:0] sz;
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), sz,
                   $urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom,
                   $urandom_range(0, 3), 1'b1);
        end

        // Reset during an ACCESS wait state
        do_txn(1'b0, 32'h1000_0050, 32'h0, 4'hF, 3'd2, 1000, 1'b0, 32'h0, 0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_apb_psel && m_apb_penable) && n < 20);
        check("reached_access", {31'd0, m_apb_penable}, 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_mid_psel", {31'd0, m_apb_psel}, 32'd0);
        check("rst_mid_penable", {31'd0, m_apb_penable}, 32'd0);
        check("rst_mid_rsp_vld", {31'd0, s_icb_rsp_vld}, 32'd0);
        #1 reset = 1'b0;
        cur_waits = 0;
        @(negedge clk);
        check("rst_mid_cmd_rdy", {31'd0, s_icb_cmd_rdy}, 32'd1);
        check("rst_mid_no_rsp", {31'd0, s_icb_rsp_vld}, 32'd0);

        do_txn(1'b0, 32'h1000_0060, 32'h0, 4'hF, 3'd2, 0, 1'b0, 32'hA5A5_5A5A, 0, 1'b1);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
